// File: rtl/distance_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : distance_pkg
//  Description : Shared definitions for the ultrasonic distance path. Holds
//                the filter state encoding, the default range and threshold
//                constants used by DISTANCE_READER, the filter and the motion
//                controller, and the obstacle hysteresis decision.
//  Revision    : 1.0 - initial release
// ============================================================================
package distance_pkg;

    // Defaults in reader distance units (cm) and 50 MHz clock cycles.
    localparam int c_MAX_DIST       = 400;
    localparam int c_NEAR_TH        = 20;
    localparam int c_FAR_TH         = 30;
    localparam int c_TIMEOUT_CYCLES = 3000000;

    // Filter operating state.
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALE = 2'd2
    } state_e;

    // Obstacle hysteresis: set below the near threshold, clear above the far
    // threshold, otherwise (including equality with either) keep the flag.
    function automatic logic next_obstacle(
        input logic        cur,
        input int unsigned avg,
        input int unsigned near_th,
        input int unsigned far_th
    );
        logic res;
        res = cur;
        if (avg < near_th) begin
            res = 1'b1;
        end else if (avg > far_th) begin
            res = 1'b0;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/distance_filter_ring.sv
`default_nettype none
// ============================================================================
//  Module      : distance_filter_ring
//  Description : DEPTH x D_WIDTH ring buffer holding the averaging window.
//                The entry at the write pointer is the oldest sample and is
//                presented combinationally so it can be subtracted from the
//                running sum in the same cycle it is overwritten.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   clock
//    rst        in   synchronous active-high reset
//    clr_i      in   synchronous clear of all entries and the write pointer
//    wr_en_i    in   write wr_data_i at the pointer and advance it
//    wr_data_i  in   sample to store
//    rd_data_o  out  oldest entry (the one the next write replaces)
// ============================================================================
module distance_filter_ring #(
    parameter int D_WIDTH    = 16,
    parameter int LOG2_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               wr_en_i,
    input  logic [D_WIDTH-1:0] wr_data_i,
    output logic [D_WIDTH-1:0] rd_data_o
);

    localparam int c_DEPTH = 1 << LOG2_DEPTH;

    logic [LOG2_DEPTH-1:0] wptr_q;
    logic [D_WIDTH-1:0]    entries_w [c_DEPTH];

    // Pointer is exactly LOG2_DEPTH bits wide, so the increment wraps
    // modulo DEPTH without an explicit compare.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            wptr_q <= '0;
        end else if (wr_en_i) begin
            wptr_q <= wptr_q + LOG2_DEPTH'(1);
        end
    end

    for (genvar i = 0; i < c_DEPTH; i++) begin : g_entry
        logic [D_WIDTH-1:0] entry_q;

        always_ff @(posedge clk) begin
            if (rst || clr_i) begin
                entry_q <= '0;
            end else if (wr_en_i && (wptr_q == LOG2_DEPTH'(i))) begin
                entry_q <= wr_data_i;
            end
        end

        assign entries_w[i] = entry_q;
    end

    assign rd_data_o = entries_w[wptr_q];

endmodule
`default_nettype wire

// File: rtl/distance_filter.sv
`default_nettype none
// ============================================================================
//  Module      : distance_filter
//  Description : Conditions ultrasonic distance samples for the motion
//                controller. Each strobed sample is clamped (no echo or out of
//                range -> MAX_DIST), folded into a moving average over
//                2^LOG2_DEPTH samples, and drives an obstacle flag with
//                hysteresis. If samples stop arriving for TIMEOUT_CYCLES the
//                filter declares the sensor stale and forces the obstacle flag.
//  Revision    : 1.0 - initial release
//
//  Ports
//    DISTANCE_FILTER_CLOCK_50        in   50 MHz system clock
//    DISTANCE_FILTER_RESET_InHigh    in   synchronous active-high reset
//    DISTANCE_FILTER_DISTANCE_InBus  in   raw distance, valid with strobe
//    DISTANCE_FILTER_SAMPLE_In       in   one-cycle sample strobe
//    DISTANCE_FILTER_AVERAGE_OutBus  out  latest moving average
//    DISTANCE_FILTER_VALID_Out       out  one-cycle pulse on average update
//    DISTANCE_FILTER_OBSTACLE_Out    out  1 = obstacle / stop
//    DISTANCE_FILTER_STALE_Out       out  sensor silent for TIMEOUT_CYCLES
// ============================================================================
module distance_filter
    import distance_pkg::*;
#(
    parameter int N_WIDTH        = 32,
    parameter int D_WIDTH        = 16,
    parameter int LOG2_DEPTH     = 2,
    parameter int MAX_DIST       = c_MAX_DIST,
    parameter int NEAR_TH        = c_NEAR_TH,
    parameter int FAR_TH         = c_FAR_TH,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES
) (
    input  logic               DISTANCE_FILTER_CLOCK_50,
    input  logic               DISTANCE_FILTER_RESET_InHigh,
    input  logic [N_WIDTH-1:0] DISTANCE_FILTER_DISTANCE_InBus,
    input  logic               DISTANCE_FILTER_SAMPLE_In,
    output logic [D_WIDTH-1:0] DISTANCE_FILTER_AVERAGE_OutBus,
    output logic               DISTANCE_FILTER_VALID_Out,
    output logic               DISTANCE_FILTER_OBSTACLE_Out,
    output logic               DISTANCE_FILTER_STALE_Out
);

    localparam int c_DEPTH   = 1 << LOG2_DEPTH;
    localparam int c_S_WIDTH = D_WIDTH + LOG2_DEPTH;
    localparam int c_T_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [N_WIDTH-1:0]    c_MAX_RAW   = N_WIDTH'(MAX_DIST);
    localparam logic [D_WIDTH-1:0]    c_MAX_D     = D_WIDTH'(MAX_DIST);
    localparam logic [c_T_WIDTH-1:0]  c_TMO_LAST  = c_T_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [LOG2_DEPTH-1:0] c_FILL_LAST = LOG2_DEPTH'(c_DEPTH - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e                  state_q;
    logic [LOG2_DEPTH-1:0]   fill_q;
    logic [c_S_WIDTH-1:0]    sum_q;
    logic [D_WIDTH-1:0]      clamp_q;
    logic                    s1_valid_q;
    logic [c_T_WIDTH-1:0]    tmo_q;
    logic [D_WIDTH-1:0]      avg_q;
    logic                    valid_q;
    logic                    obstacle_q;
    logic                    stale_q;

    // ------------------------------------------------------------------
    // Combinational next values
    // ------------------------------------------------------------------
    logic [D_WIDTH-1:0]      clamp_d;
    logic [c_S_WIDTH-1:0]    sum_d;
    logic [D_WIDTH-1:0]      avg_d;
    logic                    obstacle_d;
    logic [D_WIDTH-1:0]      ring_oldest;
    logic                    ring_clr;
    logic                    accept;
    logic                    expire;

    wire logic clk    = DISTANCE_FILTER_CLOCK_50;
    wire logic rst    = DISTANCE_FILTER_RESET_InHigh;
    wire logic sample = DISTANCE_FILTER_SAMPLE_In;

    // A zero reading means the reader saw no echo; treat it like an
    // out-of-range reading so it counts as "far" rather than "touching".
    always_comb begin
        clamp_d = DISTANCE_FILTER_DISTANCE_InBus[D_WIDTH-1:0];
        if ((DISTANCE_FILTER_DISTANCE_InBus == '0) ||
            (DISTANCE_FILTER_DISTANCE_InBus > c_MAX_RAW)) begin
            clamp_d = c_MAX_D;
        end
    end

    // The sum always contains the oldest entry, so the subtraction cannot
    // go negative; the sum width holds DEPTH * MAX without overflow.
    always_comb begin
        sum_d      = sum_q + c_S_WIDTH'(clamp_q) - c_S_WIDTH'(ring_oldest);
        avg_d      = D_WIDTH'(sum_d >> LOG2_DEPTH);
        obstacle_d = next_obstacle(obstacle_q, 32'(avg_d), NEAR_TH, FAR_TH);
    end

    // Stage-2 acceptance of the clamped sample. While stale the pipeline is
    // necessarily empty, but the guard keeps ring and sum consistent.
    assign accept = s1_valid_q && (state_q != ST_STALE);

    // Expiry only fires without a strobe; a strobe on the expiry cycle wins.
    assign expire = !sample && (tmo_q == c_TMO_LAST) && (state_q != ST_STALE);

    // Leaving STALE: the waking sample starts a fresh window, so the old
    // window contents are discarded on the cycle the strobe is seen.
    assign ring_clr = sample && (state_q == ST_STALE);

    distance_filter_ring #(
        .D_WIDTH    (D_WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (ring_clr),
        .wr_en_i   (accept),
        .wr_data_i (clamp_q),
        .rd_data_o (ring_oldest)
    );

    // ------------------------------------------------------------------
    // Clamp stage and timeout counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            clamp_q    <= '0;
            s1_valid_q <= 1'b0;
            tmo_q      <= '0;
        end else begin
            s1_valid_q <= sample;
            if (sample) begin
                clamp_q <= clamp_d;
            end
            // Counter parks at its last value, which both triggers expiry
            // and holds it saturated for the whole STALE period.
            if (sample) begin
                tmo_q <= '0;
            end else if (tmo_q != c_TMO_LAST) begin
                tmo_q <= tmo_q + c_T_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Averaging stage, state machine and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FILL;
            fill_q     <= '0;
            sum_q      <= '0;
            avg_q      <= '0;
            valid_q    <= 1'b0;
            obstacle_q <= 1'b1;
            stale_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_STALE: begin
                    if (sample) begin
                        state_q <= ST_FILL;
                        stale_q <= 1'b0;
                        fill_q  <= '0;
                        sum_q   <= '0;
                    end
                end

                ST_FILL: begin
                    if (accept) begin
                        sum_q <= sum_d;
                        if (fill_q == c_FILL_LAST) begin
                            // Window is now full: this sample is the first
                            // with a meaningful average.
                            state_q    <= ST_RUN;
                            avg_q      <= avg_d;
                            valid_q    <= 1'b1;
                            obstacle_q <= obstacle_d;
                        end else begin
                            fill_q <= fill_q + LOG2_DEPTH'(1);
                        end
                    end
                    if (expire) begin
                        state_q    <= ST_STALE;
                        stale_q    <= 1'b1;
                        obstacle_q <= 1'b1;
                        valid_q    <= 1'b0;
                    end
                end

                default: begin
                    if (accept) begin
                        sum_q      <= sum_d;
                        avg_q      <= avg_d;
                        valid_q    <= 1'b1;
                        obstacle_q <= obstacle_d;
                    end
                    if (expire) begin
                        state_q    <= ST_STALE;
                        stale_q    <= 1'b1;
                        obstacle_q <= 1'b1;
                        valid_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign DISTANCE_FILTER_AVERAGE_OutBus = avg_q;
    assign DISTANCE_FILTER_VALID_Out      = valid_q;
    assign DISTANCE_FILTER_OBSTACLE_Out   = obstacle_q;
    assign DISTANCE_FILTER_STALE_Out      = stale_q;

endmodule
`default_nettype wire

// File: doc/distance_filter.md
Name: distance_filter

Overview:
- Downstream consumer of DISTANCE_READER on the robot. Takes each new ultrasonic distance sample, clamps out-of-range values and computes a moving average over 2^LOG2_DEPTH samples.
- Drives an obstacle flag with hysteresis for the motion controller.
- Watches for a missing sensor and forces a safe "obstacle" state when samples stop arriving.

Parameters:
- N_WIDTH, 32, width of the raw distance bus from DISTANCE_READER.
- D_WIDTH, 16, internal and output distance width; MAX_DIST must fit.
- LOG2_DEPTH, 2, log2 of the averaging window (DEPTH = 4).
- MAX_DIST, 400, clamp value in reader distance units (cm).
- NEAR_TH, 20, average strictly below this sets the obstacle flag.
- FAR_TH, 30, average strictly above this clears the obstacle flag. Requires NEAR_TH < FAR_TH <= MAX_DIST.
- TIMEOUT_CYCLES, 3000000, cycles without a sample before STALE (60 ms at 50 MHz).

Ports:
- DISTANCE_FILTER_CLOCK_50  in  1  system clock, 50 MHz; the only clock.
- DISTANCE_FILTER_RESET_InHigh  in  1  reset, synchronous, active-high.
- DISTANCE_FILTER_DISTANCE_InBus  in  N_WIDTH  raw distance from DISTANCE_READER.
- DISTANCE_FILTER_SAMPLE_In  in  1  one-cycle strobe; the distance bus is valid in that cycle. DISTANCE_READER gains this strobe.
- DISTANCE_FILTER_AVERAGE_OutBus  out  D_WIDTH  latest moving average.
- DISTANCE_FILTER_VALID_Out  out  1  one-cycle pulse when AVERAGE updates.
- DISTANCE_FILTER_OBSTACLE_Out  out  1  obstacle flag (1 = stop).
- DISTANCE_FILTER_STALE_Out  out  1  sensor silent for TIMEOUT_CYCLES.

Behaviour:
- Reset values (synchronous): AVERAGE=0, VALID=0, OBSTACLE=1, STALE=0. State=FILL; fill count, running sum, ring buffer and write pointer all cleared; timeout counter=0. Reset mid-operation discards all samples in flight.
- Clamp stage (stage 1): raw==0 (no echo) or raw>MAX_DIST is treated as MAX_DIST; otherwise raw[D_WIDTH-1:0]. Result registered at T+1 for a strobe at cycle T.
- Stage 2:
  - sum <= sum + new - buffer[wptr]; buffer[wptr] <= new; wptr increments modulo DEPTH.
  - Sum width is D_WIDTH+LOG2_DEPTH, so no overflow is possible.
  - Average = sum_next >> LOG2_DEPTH, truncated.
  - AVERAGE and VALID are registered at T+2.
- One sample per cycle is accepted; back-to-back strobes are fully pipelined.
- States:
  - FILL: samples enter buffer and sum. VALID stays 0 and OBSTACLE is held at 1. On the DEPTH-th accepted sample: state goes to RUN, and that sample produces the first VALID pulse with its average.
  - RUN: every sample pulses VALID at T+2. Hysteresis is evaluated on the new average in the same cycle:
    - avg<NEAR_TH -> OBSTACLE=1.
    - avg>FAR_TH -> OBSTACLE=0.
    - Otherwise OBSTACLE holds.
    - Equality with either threshold holds.
  - STALE: entered from FILL or RUN when the timeout counter reaches TIMEOUT_CYCLES-1 with no strobe. On entry: STALE=1, OBSTACLE=1, AVERAGE holds its last value, no VALID. On the next strobe: STALE=0, sum, buffer, wptr and count are cleared, and that sample is the first FILL sample.
- Timeout counter: cleared on every strobe, otherwise increments. It saturates while in STALE.
- A strobe in the same cycle as expiry wins: no STALE, counter cleared.
- Samples in the pipeline when STALE is entered cannot exist, since a stale entry means no strobe for TIMEOUT_CYCLES.

Decomposition:
- Shared package distance_pkg holds:
  - state encoding (FILL, RUN, STALE);
  - the default MAX_DIST, NEAR_TH, FAR_TH and TIMEOUT_CYCLES constants, shared with DISTANCE_READER and the motion controller.
- One sub-module, distance_filter_ring:
  - DEPTH x D_WIDTH ring buffer with write pointer;
  - combinational read of the oldest entry;
  - synchronous clear.
- Clamp, sum, hysteresis, FSM and timeout stay in the top module.

Test Plan:
- Reset -> AVERAGE=0, VALID=0, OBSTACLE=1, STALE=0. Asserting reset mid-FILL after 2 samples, then 4 samples of 100 -> first VALID only on the 4th post-reset sample.
- Fill: 4 strobes of 100 at cycles 10, 20, 30, 40 -> no VALID for the first three. At cycle 42: VALID=1, AVERAGE=100, OBSTACLE=0.
- Set hysteresis: from steady 100, feed 10,10,10,10 -> averages 77, 55, 32, 10. OBSTACLE stays 0 until the avg=10 pulse, then becomes 1.
- Clear hysteresis: then feed 25 x4 -> averages 13, 17, 21, 25, OBSTACLE stays 1. Then 40,40 -> averages 28 (holds 1), 32 (clears to 0).
- Clamp: 4 samples of 0, 5000, 400, 401 -> AVERAGE=400. Back-to-back strobes on consecutive cycles -> 4 VALID pulses on consecutive cycles at T+2.
- Timeout (TIMEOUT_CYCLES=1000):
  - No strobe for 1000 cycles -> STALE=1 and OBSTACLE=1 at exactly cycle 1000.
  - Next strobe -> STALE=0, refill; VALID resumes only after 4 samples.
  - A strobe on the expiry cycle -> STALE stays 0.
